dot_matrix_reader: RTL and testbench
====================================

Name: dot_matrix_reader

Overview:
- Inverse of the team's BCD-to-15-dot decoder. Receives a 3x5 dot-matrix glyph serially, one 3-dot row per beat, top row first.
- Assembles the 15-bit frame, matches it against the fixed digit font and returns the 4-bit BCD code on a valid/ready output.
- Sits between a row-scanning matrix front end (or a loop-back of the decoder) and downstream digit logic.
- Used for self-check of the display path and for reading back patterned inputs.

Parameters:
- ERR_CODE, 4'hF, value driven on bcd when the frame matches no glyph.
- ROW_TIMEOUT, 16, max idle cycles allowed between consecutive rows inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- row_data  in  3  dots of the current row; bit 2 = left column, bit 0 = right column
- row_valid  in  1  row_data is valid this cycle; always accepted, no back-pressure
- row_sof  in  1  qualifies row_valid; marks row 0 (top) of a frame
- bcd  out  4  decoded digit 0-9, or ERR_CODE
- bcd_valid  out  1  bcd, glyph_err and frame are valid
- bcd_ready  in  1  downstream accepts when bcd_valid && bcd_ready
- glyph_err  out  1  frame matched no glyph; held alongside bcd
- frame  out  15  assembled frame; row r occupies bits [14-3r : 12-3r]
- sync_err  out  1  one-cycle pulse on a frame-framing error
- overrun  out  1  one-cycle pulse when a result is dropped

Behaviour:
- Reset (async, rst_n=0):
  - bcd=0, bcd_valid=0, glyph_err=0, frame=0, sync_err=0, overrun=0.
  - FSM goes to IDLE, row counter=0, match_pending=0, timeout counter=0.
- Glyph table (15-bit frame value -> digit):
  - 0x7B6F->0, 0x2C97->1, 0x73E7->2, 0x73CF->3, 0x5BC9->4
  - 0x79CF->5, 0x79EF->6, 0x7249->7, 0x7BEF->8, 0x7BCF->9
  - Any other value -> bcd=ERR_CODE, glyph_err=1.
- FSM IDLE:
  - row_valid && row_sof: store row 0, cnt=1, go to COLLECT.
  - row_valid && !row_sof: ignored, no error.
- FSM COLLECT:
  - row_valid && !row_sof: store row cnt, cnt++, clear the timeout counter.
  - On the edge that stores row 4: copy the assembled frame to the capture register, set match_pending, return to IDLE.
  - row_valid && row_sof: pulse sync_err, discard the partial frame, store the new row 0, cnt=1, stay in COLLECT.
  - ROW_TIMEOUT!=0 and the timeout counter reaches ROW_TIMEOUT with no row: pulse sync_err, return to IDLE.
- Match stage:
  - Runs when match_pending=1; clears match_pending in the same cycle.
  - If the output is free (bcd_valid=0, or bcd_ready=1 this cycle): load bcd/glyph_err/frame and assert bcd_valid.
  - Otherwise: keep the held result, drop the new one, pulse overrun.
- Latency: fifth row sampled at edge k; bcd_valid high after edge k+1.
  - Back-to-back frames at one row per cycle are sustained; collection never stalls.
- Output handshake: bcd_valid stays high and bcd/glyph_err/frame stay stable until bcd_valid && bcd_ready.
  - Acceptance with no new result that cycle: bcd_valid falls next edge.
  - Acceptance plus new result in the same cycle: bcd_valid stays high with the new data.
- rst_n asserted mid-frame or mid-hold: everything is cleared immediately; the partial frame and held result are lost.

Optional Feature:
- Macro: DOT_DEBOUNCE_EN.
- Defined:
  - The match stage compares the capture register with the last captured frame (register cleared by reset).
  - The result is offered only if both are equal and differ from the last emitted frame, i.e. one output per stable new glyph.
  - A suppressed frame is not an overrun.
- Not defined: every completed frame is offered.

Test Plan:
- Reset, then sof+rows 111,101,101,101,111 on consecutive cycles with bcd_ready=1 -> bcd=0, glyph_err=0, frame=0x7B6F, bcd_valid for exactly 1 cycle, 2 edges after the last row.
- Frame 0x7249 with bcd_ready=0 for 5 cycles, then 1 -> bcd=7 held stable for the whole wait, accepted once.
- Frame 0x7FFF (all dots) -> bcd=4'hF, glyph_err=1.
- Two rows, then a new sof followed by the full digit-5 frame -> one sync_err pulse, then bcd=5. Separately: 2 rows then 17 idle cycles -> sync_err and return to IDLE, no output.
- Frame 3 with bcd_ready=0, then frame 8 -> overrun pulse, bcd stays 3; after bcd_ready=1, bcd_valid drops.
- With DOT_DEBOUNCE_EN: frames 1,1,1,4,4 -> outputs 1 then 4 only. Without it: five outputs.

Source files
------------

// File: rtl/dot_matrix_reader.sv
// dot_matrix_reader: assembles a serial 3x5 dot-matrix glyph (one row per beat) and decodes it to BCD.
// Optional DOT_DEBOUNCE_EN: emit a result only when a frame repeats and differs from the last emitted one.
module dot_matrix_reader #(
  parameter logic [3:0] ERR_CODE    = 4'hF,
  parameter int         ROW_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  row_data,
  input  logic        row_valid,
  input  logic        row_sof,
  output logic [3:0]  bcd,
  output logic        bcd_valid,
  input  logic        bcd_ready,
  output logic        glyph_err,
  output logic [14:0] frame,
  output logic        sync_err,
  output logic        overrun
);
  localparam int TW = ROW_TIMEOUT > 1 ? $clog2(ROW_TIMEOUT) : 1;
  typedef enum logic {S_IDLE, S_COLLECT} state_t;
  state_t        r_state;
  logic [2:0]    r_cnt;
  logic [11:0]   r_asm;
  logic [14:0]   r_cap;
  logic          r_pend;
  logic [TW-1:0] r_to;
  logic [3:0]    w_digit;
  logic          w_gerr;
  logic          w_offer;
  logic          w_free;
  logic          w_tmo;

  assign w_free = !bcd_valid || bcd_ready;
  assign w_tmo  = (ROW_TIMEOUT != 0) && (int'(r_to) == ROW_TIMEOUT - 1);

  // font lookup of the captured frame
  always_comb begin
    w_digit = ERR_CODE;
    w_gerr  = 1'b0;
    case (r_cap)
      15'h7B6F: w_digit = 4'd0;
      15'h2C97: w_digit = 4'd1;
      15'h73E7: w_digit = 4'd2;
      15'h73CF: w_digit = 4'd3;
      15'h5BC9: w_digit = 4'd4;
      15'h79CF: w_digit = 4'd5;
      15'h79EF: w_digit = 4'd6;
      15'h7249: w_digit = 4'd7;
      15'h7BEF: w_digit = 4'd8;
      15'h7BCF: w_digit = 4'd9;
      default:  w_gerr  = 1'b1;
    endcase
  end

`ifdef DOT_DEBOUNCE_EN
  logic [14:0] r_last_cap;
  logic [14:0] r_last_emit;
  assign w_offer = (r_cap == r_last_cap) && (r_cap != r_last_emit);
  // history of captured and emitted frames for the stability filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_cap  <= '0;
      r_last_emit <= '0;
    end else if (r_pend) begin
      r_last_cap <= r_cap;
      if (w_offer && w_free) r_last_emit <= r_cap;
    end
  end
`else
  assign w_offer = 1'b1;
`endif

  // row collector: shifts rows in top-first, hands a full frame to the match stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_asm    <= '0;
      r_cap    <= '0;
      r_pend   <= 1'b0;
      r_to     <= '0;
      sync_err <= 1'b0;
    end else begin
      r_pend   <= 1'b0;
      sync_err <= 1'b0;
      if (r_state == S_IDLE) begin
        r_to <= '0;
        if (row_valid && row_sof) begin
          r_asm   <= {9'd0, row_data};
          r_cnt   <= 3'd1;
          r_state <= S_COLLECT;
        end
      end else if (row_valid) begin
        r_to <= '0;
        if (row_sof) begin
          sync_err <= 1'b1;
          r_asm    <= {9'd0, row_data};
          r_cnt    <= 3'd1;
        end else if (r_cnt == 3'd4) begin
          r_cap   <= {r_asm, row_data};
          r_pend  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end else begin
          r_asm <= {r_asm[8:0], row_data};
          r_cnt <= r_cnt + 3'd1;
        end
      end else if (w_tmo) begin
        sync_err <= 1'b1;
        r_cnt    <= '0;
        r_state  <= S_IDLE;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end

  // match stage and output hold register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd       <= '0;
      glyph_err <= 1'b0;
      frame     <= '0;
      bcd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (r_pend && w_offer && w_free) begin
        bcd       <= w_digit;
        glyph_err <= w_gerr;
        frame     <= r_cap;
        bcd_valid <= 1'b1;
      end else begin
        if (bcd_valid && bcd_ready) bcd_valid <= 1'b0;
        if (r_pend && w_offer) overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dot_matrix_reader.sv
// tb_dot_matrix_reader: directed and randomized check of dot_matrix_reader against a frame-level model.
module tb_dot_matrix_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  row_data = '0;
  logic        row_valid = 1'b0;
  logic        row_sof = 1'b0;
  logic [3:0]  bcd;
  logic        bcd_valid;
  logic        bcd_ready = 1'b1;
  logic        glyph_err;
  logic [14:0] frame;
  logic        sync_err;
  logic        overrun;

  int n_chk = 0, n_err = 0, n_sync = 0, n_ovr = 0, n_out = 0;
  bit rnd = 1'b0;
  logic [14:0] expq[$];
  logic [14:0] glyph [10] = '{15'h7B6F, 15'h2C97, 15'h73E7, 15'h73CF, 15'h5BC9,
                              15'h79CF, 15'h79EF, 15'h7249, 15'h7BEF, 15'h7BCF};
  logic [14:0] m_last_cap = '0, m_last_emit = '0;

  dot_matrix_reader dut (
    .clk(clk), .rst_n(rst_n), .row_data(row_data), .row_valid(row_valid), .row_sof(row_sof),
    .bcd(bcd), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready), .glyph_err(glyph_err),
    .frame(frame), .sync_err(sync_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] dec(input logic [14:0] f);
    dec = {1'b1, 4'hF};
    for (int i = 0; i < 10; i++) if (glyph[i] == f) dec = {1'b0, 4'(i)};
  endfunction

  function automatic bit offered(input logic [14:0] f);
`ifdef DOT_DEBOUNCE_EN
    offered = (f == m_last_cap) && (f != m_last_emit);
    m_last_cap = f;
    if (offered) m_last_emit = f;
`else
    offered = 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [2:0] d, input logic sof);
    row_data = d;
    row_sof = sof;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    row_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [14:0] f, input int gap_max, input bit push);
    for (int r = 0; r < 5; r++) begin
      send_row(f[14-3*r -: 3], r == 0);
      if (r < 4) repeat ($urandom_range(gap_max, 0)) tick();
    end
    if (offered(f) && push) expq.push_back(f);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", expq.size(), 0);
    tick();
  endtask

  // scoreboard: every accepted result must match the next expected frame
  always @(negedge clk) begin
    if (rst_n) begin
      if (sync_err) n_sync++;
      if (overrun) n_ovr++;
      if (bcd_valid && bcd_ready) begin
        n_out++;
        if (expq.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          logic [14:0] f;
          logic [4:0] d;
          f = expq.pop_front();
          d = dec(f);
          chk("out_bcd", bcd, d[3:0]);
          chk("out_err", glyph_err, d[4]);
          chk("out_frame", frame, f);
        end
      end
    end
  end

  // random back-pressure during the randomized phase
  always @(posedge clk) if (rnd) begin
    #1;
    bcd_ready = 1'($urandom);
  end

  initial begin
    int s0, o0, v0;
    tick();
    tick();
    chk("rst_bcd", bcd, 0);
    chk("rst_valid", bcd_valid, 0);
    chk("rst_gerr", glyph_err, 0);
    chk("rst_frame", frame, 0);
    chk("rst_sync", sync_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    tick();
    // digit 0, latency and single-cycle valid
    send_frame(15'h7B6F, 0, 1);
    chk("t1_lat0", bcd_valid, 0);
    tick();
    chk("t1_valid", bcd_valid, 1);
    chk("t1_bcd", bcd, 0);
    chk("t1_gerr", glyph_err, 0);
    chk("t1_frame", frame, 15'h7B6F);
    tick();
    chk("t1_fall", bcd_valid, 0);
    // hold under back-pressure
    bcd_ready = 1'b0;
    send_frame(15'h7249, 0, 1);
    tick();
    repeat (5) begin
      chk("t2_hold_valid", bcd_valid, 1);
      chk("t2_hold_bcd", bcd, 7);
      tick();
    end
    bcd_ready = 1'b1;
    tick();
    chk("t2_fall", bcd_valid, 0);
    // unknown glyph
    send_frame(15'h7FFF, 0, 1);
    wait_drain();
    // resync on early sof
    s0 = n_sync;
    send_row(3'b111, 1);
    send_row(3'b101, 0);
    send_frame(15'h79CF, 0, 1);
    wait_drain();
    chk("t4_sync", n_sync - s0, 1);
    // row timeout returns to idle
    s0 = n_sync;
    send_row(3'b111, 1);
    send_row(3'b101, 0);
    repeat (17) tick();
    chk("t4_tmo_sync", n_sync - s0, 1);
    repeat (3) send_row(3'b111, 0);
    repeat (3) tick();
    chk("t4_tmo_noout", bcd_valid, 0);
    // overrun while holding
    bcd_ready = 1'b0;
    o0 = n_ovr;
    send_frame(15'h73CF, 0, 1);
    tick();
    send_frame(15'h7BEF, 0, 0);
    tick();
    tick();
    chk("t5_ovr", n_ovr - o0, 1);
    chk("t5_valid", bcd_valid, 1);
    chk("t5_bcd", bcd, 3);
    bcd_ready = 1'b1;
    tick();
    chk("t5_fall", bcd_valid, 0);
    // back-to-back frames 1,1,1,4,4
    v0 = n_out;
    s0 = 0;
    foreach (glyph[i]) if (i == 1 || i == 4) s0 += 0;
    send_frame(15'h2C97, 0, 1);
    send_frame(15'h2C97, 0, 1);
    send_frame(15'h2C97, 0, 1);
    send_frame(15'h5BC9, 0, 1);
    send_frame(15'h5BC9, 0, 1);
    wait_drain();
`ifdef DOT_DEBOUNCE_EN
    chk("t6_outs", n_out - v0, 2);
`else
    chk("t6_outs", n_out - v0, 5);
`endif
    // reset while holding and mid-frame
    bcd_ready = 1'b0;
    send_frame(15'h7B6F, 0, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", bcd_valid, 0);
    chk("t7_rst_frame", frame, 0);
    expq.delete();
    m_last_cap = '0;
    m_last_emit = '0;
    tick();
    rst_n = 1'b1;
    bcd_ready = 1'b1;
    send_row(3'b111, 1);
    send_row(3'b101, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) send_row(3'b111, 0);
    repeat (3) tick();
    chk("t7_noout", bcd_valid, 0);
    // randomized frames with gaps, junk rows and random back-pressure
    s0 = n_sync;
    o0 = n_ovr;
    rnd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [14:0] f;
      repeat ($urandom_range(2, 0)) send_row(3'($urandom), 0);
      f = ($urandom_range(3, 0) != 0) ? glyph[$urandom_range(9, 0)] : 15'($urandom);
      send_frame(f, 3, 1);
      wait_drain();
    end
    rnd = 1'b0;
    bcd_ready = 1'b1;
    chk("rnd_sync", n_sync - s0, 0);
    chk("rnd_ovr", n_ovr - o0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
